// File: rtl/dmem_reader_if.sv
// Memory debug-port and output-stream signals shared between dmem_reader and its neighbours.
// The master side is the reader. The slave side is the memory plus the consumer.
interface dmem_reader_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic              out_ready;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_data;

   modport master (
      output mem_addr,
      input  mem_rdata,
      output out_valid,
      input  out_ready,
      output out_addr,
      output out_data
   );

   modport slave (
      input  mem_addr,
      output mem_rdata,
      input  out_valid,
      output out_ready,
      input  out_addr,
      input  out_data
   );
endinterface

// File: rtl/dmem_reader.sv
// dmem_reader: walks a word-aligned window of data memory through the debug port and streams
// each word with its address over valid/ready. `DMEM_READER_CHECKSUM_EN adds a running word sum.
module dmem_reader #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              in_RST,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   dmem_reader_if.master     bus,
   output logic              busy,
   output logic              done
`ifdef DMEM_READER_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(RD_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DONE} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [WAIT_W-1:0] wait_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_valid_q;
   logic              busy_q;
   logic              done_q;

   logic              hs;
   logic [ADDR_W-1:0] mem_addr_d;
   logic              base_lsb_unused;

   assign hs              = out_valid_q & bus.out_ready;
   assign mem_addr_d      = mem_addr_q + ADDR_W'(4);
   assign base_lsb_unused = ^base_addr[1:0];

   // Walk sequencer; abort outranks everything once a walk is under way.
   always_ff @(posedge clk or negedge in_RST) begin
      if (!in_RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wait_q      <= '0;
         mem_addr_q  <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if ((state_q != S_IDLE) && abort) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     busy_q <= 1'b1;
                     if (word_count == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        cnt_q      <= word_count;
                        mem_addr_q <= {base_addr[ADDR_W-1:2], 2'b00};
                        wait_q     <= WAIT_RELOAD;
                        state_q    <= S_WAIT;
                     end
                  end
               end
               S_WAIT: begin
                  if (wait_q == '0) begin
                     out_data_q  <= bus.mem_rdata;
                     out_addr_q  <= mem_addr_q;
                     out_valid_q <= 1'b1;
                     state_q     <= S_HOLD;
                  end else begin
                     wait_q <= wait_q - WAIT_W'(1);
                  end
               end
               S_HOLD: begin
                  if (hs) begin
                     out_valid_q <= 1'b0;
                     cnt_q       <= cnt_q - CNT_W'(1);
                     if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        mem_addr_q <= mem_addr_d;
                        wait_q     <= WAIT_RELOAD;
                        state_q    <= S_WAIT;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

`ifdef DMEM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   // A handshake coinciding with abort still counts as delivered.
   always_ff @(posedge clk or negedge in_RST) begin
      if (!in_RST) begin
         checksum_q <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         checksum_q <= '0;
      end else if (hs) begin
         checksum_q <= checksum_q + out_data_q;
      end
   end

   assign checksum = checksum_q;
`endif

   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_dmem_reader.sv
// Directed bench for dmem_reader: one instance at RD_LAT=1 and one at RD_LAT=3,
// each with a behavioural debug-port memory.
module tb_dmem_reader;

   logic        clk = 1'b0;
   logic        in_RST;
   logic        start1, abort1, start3, abort3;
   logic [11:0] base1, base3;
   logic [9:0]  wc1, wc3;
   logic        busy1, done1, busy3, done3;
`ifdef DMEM_READER_CHECKSUM_EN
   logic [31:0] cks1, cks3;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int hs1_cnt = 0, done1_cnt = 0;
   bit valid_seen1 = 1'b0;

   dmem_reader_if #(.ADDR_W(12), .DATA_W(32)) bus1 ();
   dmem_reader_if #(.ADDR_W(12), .DATA_W(32)) bus3 ();

   always #5 clk = ~clk;

   dmem_reader #(.ADDR_W(12), .DATA_W(32), .CNT_W(10), .RD_LAT(1)) u_dut1 (
      .clk        (clk),
      .in_RST     (in_RST),
      .start      (start1),
      .abort      (abort1),
      .base_addr  (base1),
      .word_count (wc1),
      .bus        (bus1),
      .busy       (busy1),
      .done       (done1)
`ifdef DMEM_READER_CHECKSUM_EN
      ,
      .checksum   (cks1)
`endif
   );

   dmem_reader #(.ADDR_W(12), .DATA_W(32), .CNT_W(10), .RD_LAT(3)) u_dut3 (
      .clk        (clk),
      .in_RST     (in_RST),
      .start      (start3),
      .abort      (abort3),
      .base_addr  (base3),
      .word_count (wc3),
      .bus        (bus3),
      .busy       (busy3),
      .done       (done3)
`ifdef DMEM_READER_CHECKSUM_EN
      ,
      .checksum   (cks3)
`endif
   );

   // RD_LAT=1 memory: combinational read, word n holds 0x1000+n.
   assign bus1.mem_rdata = 32'h1000 + 32'(bus1.mem_addr[11:2]);

   // RD_LAT=3 memory: address delayed two edges then read combinationally.
   logic [11:0] p1, p2;
   always @(posedge clk) begin
      p1 <= bus3.mem_addr;
      p2 <= p1;
   end

   function automatic logic [31:0] mem3(input logic [11:0] a);
      case (a[11:2])
         10'd4:   mem3 = 32'hFFFF_FFFF;
         10'd5:   mem3 = 32'h0000_0002;
         default: mem3 = 32'h3000 + 32'(a[11:2]);
      endcase
   endfunction
   assign bus3.mem_rdata = mem3(p2);

   always @(posedge clk) begin
      if (bus1.out_valid && bus1.out_ready) hs1_cnt++;
      if (done1) done1_cnt++;
      if (bus1.out_valid) valid_seen1 = 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Steps until the selected instance presents a word (bounded), then checks it.
   task automatic wait_word(input bit sel, input string tag, input logic [11:0] ea,
                            input logic [31:0] ed, output int steps);
      logic v;
      steps = 0;
      do begin
         @(negedge clk);
         steps++;
         v = sel ? bus3.out_valid : bus1.out_valid;
      end while (!v && steps < 20);
      check({tag, "_valid"}, 64'(v), 64'(1));
      check({tag, "_addr"}, 64'(sel ? bus3.out_addr : bus1.out_addr), 64'(ea));
      check({tag, "_data"}, 64'(sel ? bus3.out_data : bus1.out_data), 64'(ed));
   endtask

   initial begin
      int s, h0, d0;
      in_RST = 1'b0;
      start1 = 0; abort1 = 0; base1 = '0; wc1 = '0; bus1.out_ready = 0;
      start3 = 0; abort3 = 0; base3 = '0; wc3 = '0; bus3.out_ready = 0;
      step(2);
      check("rst_mem_addr", 64'(bus1.mem_addr), 64'(0));
      check("rst_valid", 64'(bus1.out_valid), 64'(0));
      check("rst_busy", 64'(busy1), 64'(0));
      check("rst_done", 64'(done1), 64'(0));
      check("rst_data", 64'(bus1.out_data), 64'(0));
      in_RST = 1'b1;
      step(1);

      // Basic walk
      bus1.out_ready = 1; base1 = 12'h010; wc1 = 10'd3; start1 = 1; h0 = hs1_cnt;
      step(1);
      start1 = 0;
      check("bw_mem_addr", 64'(bus1.mem_addr), 64'h010);
      check("bw_busy", 64'(busy1), 64'(1));
      check("bw_valid_low", 64'(bus1.out_valid), 64'(0));
      wait_word(0, "bw0", 12'h010, 32'h1004, s); check("bw0_lat", 64'(s), 64'(1));
      wait_word(0, "bw1", 12'h014, 32'h1005, s); check("bw1_gap", 64'(s), 64'(2));
      wait_word(0, "bw2", 12'h018, 32'h1006, s); check("bw2_gap", 64'(s), 64'(2));
      step(1);
      check("bw_done", 64'(done1), 64'(1));
      check("bw_done_busy", 64'(busy1), 64'(1));
      check("bw_done_valid", 64'(bus1.out_valid), 64'(0));
      step(1);
      check("bw_done_pulse", 64'(done1), 64'(0));
      check("bw_idle_busy", 64'(busy1), 64'(0));
      check("bw_words", 64'(hs1_cnt - h0), 64'(3));
`ifdef DMEM_READER_CHECKSUM_EN
      check("bw_checksum", 64'(cks1), 64'h300F);
`endif

      // Backpressure
      bus1.out_ready = 0; base1 = 12'h010; wc1 = 10'd3; start1 = 1; h0 = hs1_cnt;
      step(1);
      start1 = 0;
      wait_word(0, "bp0", 12'h010, 32'h1004, s);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("bp_hold_valid", 64'(bus1.out_valid), 64'(1));
         check("bp_hold_addr", 64'(bus1.out_addr), 64'h010);
         check("bp_hold_data", 64'(bus1.out_data), 64'h1004);
      end
      bus1.out_ready = 1;
      wait_word(0, "bp1", 12'h014, 32'h1005, s);
      wait_word(0, "bp2", 12'h018, 32'h1006, s);
      step(1);
      check("bp_done", 64'(done1), 64'(1));
      step(1);
      check("bp_words", 64'(hs1_cnt - h0), 64'(3));

      // Address wrap
      base1 = 12'hFFE; wc1 = 10'd2; start1 = 1;
      step(1);
      start1 = 0;
      check("wr_mem_addr", 64'(bus1.mem_addr), 64'hFFC);
      wait_word(0, "wr0", 12'hFFC, 32'h13FF, s);
      wait_word(0, "wr1", 12'h000, 32'h1000, s);
      step(1);
      check("wr_done", 64'(done1), 64'(1));
      step(1);

      // Zero word count
      valid_seen1 = 1'b0; base1 = 12'h040; wc1 = 10'd0; start1 = 1;
      step(1);
      start1 = 0;
      check("z_done", 64'(done1), 64'(1));
      check("z_busy", 64'(busy1), 64'(1));
      step(1);
      check("z_done_end", 64'(done1), 64'(0));
      check("z_busy_end", 64'(busy1), 64'(0));
      check("z_no_valid", 64'(valid_seen1), 64'(0));
      check("z_no_read", 64'(bus1.mem_addr), 64'h000);

      // Abort in HOLD of the second of four words
      bus1.out_ready = 0; base1 = 12'h100; wc1 = 10'd4; start1 = 1;
      step(1);
      start1 = 0;
      wait_word(0, "ab0", 12'h100, 32'h1040, s);
      bus1.out_ready = 1;
      step(1);
      bus1.out_ready = 0;
      wait_word(0, "ab1", 12'h104, 32'h1041, s);
      d0 = done1_cnt; abort1 = 1;
      step(1);
      abort1 = 0;
      check("ab_busy", 64'(busy1), 64'(0));
      check("ab_valid", 64'(bus1.out_valid), 64'(0));
      check("ab_done", 64'(done1), 64'(0));
      step(3);
      check("ab_no_done", 64'(done1_cnt - d0), 64'(0));
      check("ab_stay_idle", 64'(busy1), 64'(0));

      // Restart; start while busy is ignored
      bus1.out_ready = 1; base1 = 12'h200; wc1 = 10'd2; start1 = 1;
      step(1);
      base1 = 12'h300; wc1 = 10'd1;
      wait_word(0, "rs0", 12'h200, 32'h1080, s);
      start1 = 0;
      wait_word(0, "rs1", 12'h204, 32'h1081, s);
      step(1);
      check("rs_done", 64'(done1), 64'(1));
      step(1);
      check("rs_idle", 64'(busy1), 64'(0));

      // Asynchronous reset in WAIT
      base1 = 12'h010; wc1 = 10'd3; start1 = 1;
      step(1);
      start1 = 0;
      #2 in_RST = 1'b0;
      #1;
      check("ar_mem_addr", 64'(bus1.mem_addr), 64'(0));
      check("ar_out_addr", 64'(bus1.out_addr), 64'(0));
      check("ar_out_data", 64'(bus1.out_data), 64'(0));
      check("ar_valid", 64'(bus1.out_valid), 64'(0));
      check("ar_busy", 64'(busy1), 64'(0));
      check("ar_done", 64'(done1), 64'(0));
      d0 = done1_cnt;
      @(negedge clk);
      in_RST = 1'b1;
      step(4);
      check("ar_no_done", 64'(done1_cnt - d0), 64'(0));
      check("ar_idle", 64'(busy1), 64'(0));

      // RD_LAT=3 latency and checksum wrap
      bus3.out_ready = 1; base3 = 12'h010; wc3 = 10'd2; start3 = 1;
      step(1);
      start3 = 0;
      wait_word(1, "l3w0", 12'h010, 32'hFFFF_FFFF, s); check("l3w0_lat", 64'(s), 64'(3));
      wait_word(1, "l3w1", 12'h014, 32'h0000_0002, s); check("l3w1_lat", 64'(s - 1), 64'(3));
      step(1);
      check("l3_done", 64'(done3), 64'(1));
`ifdef DMEM_READER_CHECKSUM_EN
      check("l3_checksum", 64'(cks3), 64'h1);
`endif
      step(1);
      check("l3_idle", 64'(busy3), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
